wb_decoder_2: RTL and testbench

- Single-master to two-slave Wishbone (classic cycle) address decoder and router: the fan-out counterpart of the bus arbiter.
- Sits between one arbitrated master port and two slave regions.
- Routes each transfer to the slave whose address window matches.
- Returns an error for unmapped addresses, and a timeout error for a slave that never terminates.
- Keeps saturating error statistics.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_addr_match.sv | 23 ++
 rtl/wb_decoder_2.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_decoder_2.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : wb_pkg                                                       |
// | Description : Shared types and constants for the Wishbone address decoder. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package wb_pkg;

    localparam int c_err_cnt_width = 8;

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_busy     = 2'd1;
    localparam logic [1:0] c_st_err_resp = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = c_st_idle,
        BUSY     = c_st_busy,
        ERR_RESP = c_st_err_resp
    } wb_dec_state_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_addr_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_addr_match                                                |
// | Description : Combinational base/mask address window comparator.           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module wb_addr_match
    import wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
    parameter logic [ADDR_WIDTH-1:0] MASK       = '0
) (
    input  logic [ADDR_WIDTH-1:0] adr,
    output logic                  hit
);

    localparam logic [ADDR_WIDTH-1:0] c_base_masked = BASE & MASK;

    assign hit = ((adr & MASK) == c_base_masked);

endmodule : wb_addr_match
`default_nettype wire

// File: rtl/wb_decoder_2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_decoder_2                                                 |
// | Description : One-master to two-slave Wishbone classic address decoder     |
// |               with unmapped-access error, slave timeout and error count.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module wb_decoder_2
    import wb_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] SLV0_BASE      = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] SLV0_MASK      = 32'hF000_0000,
    parameter logic [ADDR_WIDTH-1:0] SLV1_BASE      = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] SLV1_MASK      = 32'hF000_0000,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // master port
    input  logic [ADDR_WIDTH-1:0]      wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]      wbm_dat_i,
    input  logic [SELECT_WIDTH-1:0]    wbm_sel_i,
    input  logic                       wbm_we_i,
    input  logic                       wbm_stb_i,
    input  logic                       wbm_cyc_i,
    output logic [DATA_WIDTH-1:0]      wbm_dat_o,
    output logic                       wbm_ack_o,
    output logic                       wbm_err_o,
    output logic                       wbm_rty_o,
    // slave 0
    output logic [ADDR_WIDTH-1:0]      wbs0_adr_o,
    output logic [DATA_WIDTH-1:0]      wbs0_dat_o,
    output logic [SELECT_WIDTH-1:0]    wbs0_sel_o,
    output logic                       wbs0_we_o,
    output logic                       wbs0_stb_o,
    output logic                       wbs0_cyc_o,
    input  logic [DATA_WIDTH-1:0]      wbs0_dat_i,
    input  logic                       wbs0_ack_i,
    input  logic                       wbs0_err_i,
    input  logic                       wbs0_rty_i,
    // slave 1
    output logic [ADDR_WIDTH-1:0]      wbs1_adr_o,
    output logic [DATA_WIDTH-1:0]      wbs1_dat_o,
    output logic [SELECT_WIDTH-1:0]    wbs1_sel_o,
    output logic                       wbs1_we_o,
    output logic                       wbs1_stb_o,
    output logic                       wbs1_cyc_o,
    input  logic [DATA_WIDTH-1:0]      wbs1_dat_i,
    input  logic                       wbs1_ack_i,
    input  logic                       wbs1_err_i,
    input  logic                       wbs1_rty_i,
    // status
    output logic                       decode_err_o,
    output logic                       timeout_o,
    output logic [c_err_cnt_width-1:0] err_cnt_o
);

    // A zero-cycle timeout still needs a 1-bit counter to keep the declarations legal.
    localparam int c_tmo_width = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_tmo_width-1:0] c_tmo_limit = c_tmo_width'(TIMEOUT_CYCLES);
    localparam bit c_tmo_enable = (TIMEOUT_CYCLES > 0);

    wb_dec_state_t              r_state;
    wb_dec_state_t              w_state_nxt;
    logic                       r_sel;
    logic                       w_sel_nxt;
    logic [c_tmo_width-1:0]     r_tmo_cnt;
    logic [c_tmo_width-1:0]     w_tmo_nxt;
    logic [c_err_cnt_width-1:0] r_err_cnt;

    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_req;
    logic                  w_miss;
    logic                  w_busy;
    logic                  w_tmo_hit;
    logic                  w_sel_ack;
    logic                  w_sel_err;
    logic                  w_sel_rty;
    logic [DATA_WIDTH-1:0] w_sel_dat;
    logic                  w_fwd_ack;
    logic                  w_fwd_err;
    logic                  w_fwd_rty;
    logic                  w_term;
    logic                  w_decode_err;
    logic                  w_timeout;
    logic                  w_slv_strobe_en;

    wb_addr_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE       (SLV0_BASE),
        .MASK       (SLV0_MASK)
    ) u_match0 (
        .adr (wbm_adr_i),
        .hit (w_hit0)
    );

    wb_addr_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE       (SLV1_BASE),
        .MASK       (SLV1_MASK)
    ) u_match1 (
        .adr (wbm_adr_i),
        .hit (w_hit1)
    );

    assign w_req  = wbm_cyc_i & wbm_stb_i;
    assign w_miss = ~(w_hit0 | w_hit1);
    assign w_busy = (r_state == BUSY);

    assign w_tmo_hit = c_tmo_enable && (r_tmo_cnt == c_tmo_limit);

    assign w_sel_ack = r_sel ? wbs1_ack_i : wbs0_ack_i;
    assign w_sel_err = r_sel ? wbs1_err_i : wbs0_err_i;
    assign w_sel_rty = r_sel ? wbs1_rty_i : wbs0_rty_i;
    assign w_sel_dat = r_sel ? wbs1_dat_i : wbs0_dat_i;

    // Prioritise ack over err over rty so the master never sees two terminations.
    assign w_fwd_ack = w_busy & w_sel_ack;
    assign w_fwd_err = w_busy & w_sel_err & ~w_sel_ack;
    assign w_fwd_rty = w_busy & w_sel_rty & ~w_sel_ack & ~w_sel_err;
    assign w_term    = w_sel_ack | w_sel_err | w_sel_rty;

    assign w_decode_err    = (r_state == IDLE) & w_req & w_miss;
    assign w_timeout       = w_busy & wbm_cyc_i & w_tmo_hit & ~w_term;
    assign w_slv_strobe_en = w_busy & ~w_tmo_hit;

    // Slave request fan-out; the unselected slave is held fully quiet.
    always_comb begin
        wbs0_adr_o = '0;
        wbs0_dat_o = '0;
        wbs0_sel_o = '0;
        wbs0_we_o  = 1'b0;
        wbs0_stb_o = 1'b0;
        wbs0_cyc_o = 1'b0;
        wbs1_adr_o = '0;
        wbs1_dat_o = '0;
        wbs1_sel_o = '0;
        wbs1_we_o  = 1'b0;
        wbs1_stb_o = 1'b0;
        wbs1_cyc_o = 1'b0;
        if (w_busy) begin
            if (!r_sel) begin
                wbs0_adr_o = wbm_adr_i;
                wbs0_dat_o = wbm_dat_i;
                wbs0_sel_o = wbm_sel_i;
                wbs0_we_o  = wbm_we_i;
                wbs0_stb_o = wbm_stb_i & w_slv_strobe_en;
                wbs0_cyc_o = wbm_cyc_i & w_slv_strobe_en;
            end else begin
                wbs1_adr_o = wbm_adr_i;
                wbs1_dat_o = wbm_dat_i;
                wbs1_sel_o = wbm_sel_i;
                wbs1_we_o  = wbm_we_i;
                wbs1_stb_o = wbm_stb_i & w_slv_strobe_en;
                wbs1_cyc_o = wbm_cyc_i & w_slv_strobe_en;
            end
        end
    end

    assign wbm_dat_o = w_busy ? w_sel_dat : '0;
    assign wbm_ack_o = w_fwd_ack;
    assign wbm_err_o = w_fwd_err | ((r_state == ERR_RESP) & wbm_cyc_i);
    assign wbm_rty_o = w_fwd_rty;

    assign decode_err_o = w_decode_err;
    assign timeout_o    = w_timeout;
    assign err_cnt_o    = r_err_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_tmo_nxt   = r_tmo_cnt;
        case (r_state)
            IDLE: begin
                w_tmo_nxt = '0;
                if (w_req) begin
                    // Slave 0 wins when both windows overlap.
                    w_sel_nxt   = ~w_hit0 & w_hit1;
                    w_state_nxt = w_miss ? ERR_RESP : BUSY;
                end
            end
            BUSY: begin
                if (!wbm_cyc_i || w_term) begin
                    w_state_nxt = IDLE;
                    w_tmo_nxt   = '0;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ERR_RESP;
                    w_tmo_nxt   = '0;
                end else if (c_tmo_enable) begin
                    w_tmo_nxt = r_tmo_cnt + 1'b1;
                end
            end
            ERR_RESP: begin
                w_state_nxt = IDLE;
                w_tmo_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_tmo_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sel     <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_tmo_cnt <= w_tmo_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if ((w_decode_err || w_timeout) && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

endmodule : wb_decoder_2
`default_nettype wire

// File: tb/tb_wb_decoder_2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_decoder_2                                              |
// | Description : Scoreboard bench for wb_decoder_2 with two slave models.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_wb_decoder_2;

    localparam logic [31:0] c_s0_data = 32'hDEAD_BEEF;
    localparam logic [31:0] c_s1_data = 32'hCAFE_0001;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbm_adr_i = '0;
    logic [31:0] wbm_dat_i = '0;
    logic [3:0]  wbm_sel_i = '0;
    logic        wbm_we_i = 1'b0;
    logic        wbm_stb_i = 1'b0;
    logic        wbm_cyc_i = 1'b0;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [31:0] wbs0_adr_o, wbs0_dat_o, wbs1_adr_o, wbs1_dat_o;
    logic [3:0]  wbs0_sel_o, wbs1_sel_o;
    logic        wbs0_we_o, wbs0_stb_o, wbs0_cyc_o;
    logic        wbs1_we_o, wbs1_stb_o, wbs1_cyc_o;
    logic        s0_ack = 1'b0;
    logic        s1_ack = 1'b0;
    logic        decode_err_o, timeout_o;
    logic [7:0]  err_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb_q[$];

    // slave model controls and captures
    logic        s0_en = 1'b0, s1_en = 1'b0;
    int          s0_delay = 2, s1_delay = 1;
    int          s0_cnt = 0, s1_cnt = 0;
    logic        s0_seen, s1_seen;
    logic [31:0] s0_cap_adr = '0, s1_cap_adr = '0, s1_cap_dat = '0;
    logic [3:0]  s1_cap_sel = '0;
    logic        s0_cap_we = 1'b1, s1_cap_we = 1'b0;

    // monitor event counters
    int cnt_s0_stb = 0, cnt_s1_stb = 0, cnt_dec = 0, cnt_tmo = 0, cnt_err = 0, cnt_ack = 0;
    logic [7:0] exp_err_cnt = '0;

    wb_decoder_2 #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wbm_adr_i    (wbm_adr_i),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_sel_i    (wbm_sel_i),
        .wbm_we_i     (wbm_we_i),
        .wbm_stb_i    (wbm_stb_i),
        .wbm_cyc_i    (wbm_cyc_i),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_ack_o    (wbm_ack_o),
        .wbm_err_o    (wbm_err_o),
        .wbm_rty_o    (wbm_rty_o),
        .wbs0_adr_o   (wbs0_adr_o),
        .wbs0_dat_o   (wbs0_dat_o),
        .wbs0_sel_o   (wbs0_sel_o),
        .wbs0_we_o    (wbs0_we_o),
        .wbs0_stb_o   (wbs0_stb_o),
        .wbs0_cyc_o   (wbs0_cyc_o),
        .wbs0_dat_i   (c_s0_data),
        .wbs0_ack_i   (s0_ack),
        .wbs0_err_i   (1'b0),
        .wbs0_rty_i   (1'b0),
        .wbs1_adr_o   (wbs1_adr_o),
        .wbs1_dat_o   (wbs1_dat_o),
        .wbs1_sel_o   (wbs1_sel_o),
        .wbs1_we_o    (wbs1_we_o),
        .wbs1_stb_o   (wbs1_stb_o),
        .wbs1_cyc_o   (wbs1_cyc_o),
        .wbs1_dat_i   (c_s1_data),
        .wbs1_ack_i   (s1_ack),
        .wbs1_err_i   (1'b0),
        .wbs1_rty_i   (1'b0),
        .decode_err_o (decode_err_o),
        .timeout_o    (timeout_o),
        .err_cnt_o    (err_cnt_o)
    );

    initial forever #5 clk = ~clk;

    // Slave models: sample the request of the cycle just ended, answer #1 later.
    always @(posedge clk) begin
        s0_seen = wbs0_cyc_o && wbs0_stb_o;
        if (s0_seen) begin
            s0_cap_adr = wbs0_adr_o;
            s0_cap_we  = wbs0_we_o;
        end
        #1;
        if (s0_seen && s0_en && !s0_ack) begin
            s0_cnt++;
            if (s0_cnt >= s0_delay) s0_ack = 1'b1;
        end else begin
            s0_ack = 1'b0;
            s0_cnt = 0;
        end
    end

    always @(posedge clk) begin
        s1_seen = wbs1_cyc_o && wbs1_stb_o;
        if (s1_seen) begin
            s1_cap_adr = wbs1_adr_o;
            s1_cap_dat = wbs1_dat_o;
            s1_cap_sel = wbs1_sel_o;
            s1_cap_we  = wbs1_we_o;
        end
        #1;
        if (s1_seen && s1_en && !s1_ack) begin
            s1_cnt++;
            if (s1_cnt >= s1_delay) s1_ack = 1'b1;
        end else begin
            s1_ack = 1'b0;
            s1_cnt = 0;
        end
    end

    // Scoreboard monitor: every master termination must match the next expectation.
    always @(negedge clk) begin
        if (wbs0_stb_o) cnt_s0_stb++;
        if (wbs1_stb_o) cnt_s1_stb++;
        if (decode_err_o) cnt_dec++;
        if (timeout_o) cnt_tmo++;
        if (wbm_err_o) cnt_err++;
        if (wbm_ack_o) cnt_ack++;
        if (rst_n && (wbm_ack_o || wbm_err_o || wbm_rty_o)) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected ack=%0b err=%0b rty=%0b dat=%h", wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o} !== {e.ack, e.err, 1'b0, e.dat}) begin
                    n_errors++;
                    $display("FAIL sb_response actual ack=%0b err=%0b rty=%0b dat=%h required ack=%0b err=%0b rty=0 dat=%h",
                             wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o, e.ack, e.err, e.dat);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic ack, input logic err, input logic [31:0] dat);
        exp_t e;
        e.ack = ack;
        e.err = err;
        e.dat = dat;
        sb_q.push_back(e);
    endtask

    task automatic bump_err_cnt();
        if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
    endtask

    // One master transfer; k counts cycles from the first cycle stb is asserted.
    task automatic do_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, input int budget, output int resp_k, output int stb_k);
        bit done;
        @(posedge clk);
        #1;
        wbm_adr_i = adr;
        wbm_dat_i = dat;
        wbm_sel_i = sel;
        wbm_we_i  = we;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        resp_k = -1;
        stb_k  = -1;
        done   = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (stb_k < 0 && (wbs0_stb_o || wbs1_stb_o)) stb_k = k;
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
                resp_k = k;
                done   = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL xfer_no_response adr=%h budget=%0d", adr, budget);
        end
        @(posedge clk);
        #1;
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_we_i  = 1'b0;
        wbm_adr_i = '0;
        wbm_dat_i = '0;
        wbm_sel_i = '0;
    endtask

    initial begin
        int rk, sk, d_s0, d_s1, d_dec, d_tmo, d_err, d_ack;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {wbm_ack_o, wbm_err_o, wbm_rty_o, decode_err_o, timeout_o,
                              wbs0_cyc_o, wbs0_stb_o, wbs1_cyc_o, wbs1_stb_o}, '0);
        check("rst_dat", wbm_dat_o, '0);
        check("rst_err_cnt", err_cnt_o, '0);
        rst_n = 1'b1;

        // slave 0 read
        s0_en = 1'b1; s0_delay = 2;
        d_s1 = cnt_s1_stb;
        push_exp(1'b1, 1'b0, c_s0_data);
        do_xfer(32'h0000_0010, '0, 4'hF, 1'b0, 20, rk, sk);
        check("s0_stb_latency", sk, 1);
        check("s0_ack_cycle", rk, 3);
        check("s0_slave_adr_we", {s0_cap_adr, 31'd0, s0_cap_we}, {32'h0000_0010, 32'd0});
        check("s0_rd_s1_quiet", cnt_s1_stb - d_s1, 0);

        // slave 1 write
        s1_en = 1'b1; s1_delay = 1;
        d_s0 = cnt_s0_stb; d_ack = cnt_ack;
        push_exp(1'b1, 1'b0, c_s1_data);
        do_xfer(32'h1000_0004, 32'h1234_5678, 4'b0011, 1'b1, 20, rk, sk);
        check("s1_wr_ack_cycle", rk, 2);
        check("s1_wr_fields", {s1_cap_adr, s1_cap_dat, 27'd0, s1_cap_sel, s1_cap_we},
              {32'h1000_0004, 32'h1234_5678, 27'd0, 4'b0011, 1'b1});
        check("s1_wr_ack_count", cnt_ack - d_ack, 1);
        check("s1_wr_s0_quiet", cnt_s0_stb - d_s0, 0);
        check("s1_wr_err_cnt", err_cnt_o, exp_err_cnt);

        // unmapped access
        d_dec = cnt_dec; d_err = cnt_err; d_s0 = cnt_s0_stb; d_s1 = cnt_s1_stb;
        push_exp(1'b0, 1'b1, '0);
        bump_err_cnt();
        do_xfer(32'h2000_0000, '0, 4'hF, 1'b0, 10, rk, sk);
        check("unmap_err_cycle", rk, 1);
        check("unmap_no_stb", (cnt_s0_stb - d_s0) + (cnt_s1_stb - d_s1), 0);
        check("unmap_dec_pulse", cnt_dec - d_dec, 1);
        check("unmap_err_width", cnt_err - d_err, 1);
        check("unmap_err_cnt", err_cnt_o, exp_err_cnt);

        // abort three cycles into BUSY, then back-to-back slave 1 read
        s0_en = 1'b0;
        @(posedge clk);
        #1;
        wbm_adr_i = 32'h0000_0020; wbm_sel_i = 4'hF; wbm_we_i = 1'b0;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_busy_cyc", {wbs0_cyc_o, wbs0_stb_o}, 2'b11);
        @(posedge clk);
        #1;
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        #1;
        check("abort_same_cycle_drop", {wbs0_cyc_o, wbs0_stb_o, wbm_err_o}, 3'b000);
        push_exp(1'b1, 1'b0, c_s1_data);
        do_xfer(32'h1000_0008, '0, 4'hF, 1'b0, 20, rk, sk);
        check("b2b_s1_stb_latency", sk, 1);
        check("b2b_s1_ack_cycle", rk, 2);

        // timeout with a mute slave 0
        d_s0 = cnt_s0_stb; d_tmo = cnt_tmo; d_err = cnt_err;
        push_exp(1'b0, 1'b1, '0);
        bump_err_cnt();
        do_xfer(32'h0000_0100, '0, 4'hF, 1'b0, 20, rk, sk);
        check("tmo_stb_cycles", cnt_s0_stb - d_s0, 8);
        check("tmo_pulse", cnt_tmo - d_tmo, 1);
        check("tmo_err_cycle", rk, 10);
        check("tmo_err_width", cnt_err - d_err, 1);
        check("tmo_err_cnt", err_cnt_o, exp_err_cnt);

        // asynchronous reset mid-BUSY
        @(posedge clk);
        #1;
        wbm_adr_i = 32'h0000_0010; wbm_sel_i = 4'hF;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_pre_busy", wbs0_stb_o, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_err_cnt = '0;
        #1;
        check("rstmid_slave_quiet", {wbs0_cyc_o, wbs0_stb_o, wbs1_cyc_o, wbs1_stb_o}, 4'b0000);
        check("rstmid_slave_bus", {wbs0_adr_o, wbs0_dat_o, wbs0_sel_o}, '0);
        check("rstmid_master_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o, decode_err_o}, 5'b00000);
        check("rstmid_err_cnt", err_cnt_o, 8'h00);
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_adr_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        s0_en = 1'b1;
        push_exp(1'b1, 1'b0, c_s0_data);
        do_xfer(32'h0000_0010, '0, 4'hF, 1'b0, 20, rk, sk);
        check("rstmid_after_latency", sk, 1);
        check("rstmid_after_ack", rk, 3);

        // saturation of the error counter
        for (int i = 0; i < 260; i++) begin
            push_exp(1'b0, 1'b1, '0);
            bump_err_cnt();
            do_xfer(32'h3000_0000 + 32'(i), '0, 4'hF, 1'b0, 6, rk, sk);
            if (i == 253) check("sat_err_cnt_254", err_cnt_o, 8'hFE);
            if (i == 254) check("sat_err_cnt_255", err_cnt_o, 8'hFF);
        end
        check("sat_err_cnt_260", err_cnt_o, 8'hFF);
        check("sat_model_cnt", err_cnt_o, exp_err_cnt);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

endmodule : tb_wb_decoder_2
`default_nettype wire
